// File: rtl/shift_subtractor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_subtractor_pkg                                                     |
// | State encoding and width helpers for the restoring shift-subtract divider|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package shift_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

  // The partial remainder needs one guard bit above the operand width.
  function automatic int rem_width(input int width);
    return width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_subtractor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_subtractor_if                                                      |
// | Operand/result handshake bundle; div_zero exists with                    |
// | SHIFT_SUBTRACTOR_DIV0_EN.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface shift_subtractor_if #(
  parameter int LOG2_WIDTH = 2
) ();
  localparam int WIDTH = 2 ** LOG2_WIDTH;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dout_valid;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
  logic             div_zero;

  modport master (
    output dividend, divisor, din_valid,
    input  din_ready, quotient, remainder, dout_valid, div_zero
  );
  modport slave (
    input  dividend, divisor, din_valid,
    output din_ready, quotient, remainder, dout_valid, div_zero
  );
`else
  modport master (
    output dividend, divisor, din_valid,
    input  din_ready, quotient, remainder, dout_valid
  );
  modport slave (
    input  dividend, divisor, din_valid,
    output din_ready, quotient, remainder, dout_valid
  );
`endif

endinterface
`default_nettype wire

// File: rtl/shift_subtractor_div_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_step                                                                 |
// | One combinational restoring division step: shift in a bit, trial-subtract|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_step
  import shift_subtractor_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int REM_W = rem_width(WIDTH)
) (
  input  wire logic [REM_W-1:0] rem_in,
  input  wire logic             bit_in,
  input  wire logic [WIDTH-1:0] divisor,
  output logic      [REM_W-1:0] rem_out,
  output logic                  q_bit
);

  logic [REM_W:0]   shifted;
  logic [REM_W-1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted[REM_W-1:0] - REM_W'(divisor);
    q_bit   = (shifted >= (REM_W + 1)'(divisor));
    rem_out = q_bit ? diff : shifted[REM_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/shift_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_subtractor                                                         |
// | Iterative unsigned restoring divider, one quotient bit per clock.        |
// | Option macro: SHIFT_SUBTRACTOR_DIV0_EN (divide-by-zero bypass + flag).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shift_subtractor
  import shift_subtractor_pkg::*;
#(
  parameter int LOG2_WIDTH = 2
) (
  input wire logic          clk,
  input wire logic          rst_n,
  shift_subtractor_if.slave bus
);

  localparam int WIDTH = 2 ** LOG2_WIDTH;
  localparam int REM_W = rem_width(WIDTH);

  state_e                state_q, state_d;
  logic [LOG2_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      dvd_q, dvd_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]      quotient_q, quotient_d;
  logic [WIDTH-1:0]      remainder_q, remainder_d;
  logic                  dout_valid_q, dout_valid_d;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
  logic                  div_zero_q, div_zero_d;
`endif

  logic [REM_W-1:0]      step_rem;
  logic                  step_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    dout_valid_d = 1'b0;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
    div_zero_d   = div_zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
          // Zero divisor skips the iteration and reports its fixed result now.
          if (bus.divisor == '0) begin
            state_d      = DONE;
            quotient_d   = '1;
            remainder_d  = bus.dividend;
            div_zero_d   = 1'b1;
            dout_valid_d = 1'b1;
          end
`endif
        end
      end

      CALC: begin
        // The dividend register doubles as the quotient accumulator.
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {LOG2_WIDTH{1'b1}}) begin
          state_d      = DONE;
          quotient_d   = {dvd_q[WIDTH-2:0], step_q};
          remainder_d  = step_rem[WIDTH-1:0];
          dout_valid_d = 1'b1;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
          div_zero_d   = 1'b0;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      dout_valid_q <= 1'b0;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
      div_zero_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      dout_valid_q <= dout_valid_d;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
      div_zero_q   <= div_zero_d;
`endif
    end
  end

  assign bus.din_ready  = (state_q == IDLE);
  assign bus.quotient   = quotient_q;
  assign bus.remainder  = remainder_q;
  assign bus.dout_valid = dout_valid_q;
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
  assign bus.div_zero   = div_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_subtractor                                                      |
// | Self-checking bench for shift_subtractor (WIDTH=4); honours              |
// | SHIFT_SUBTRACTOR_DIV0_EN.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_shift_subtractor;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  shift_subtractor_if #(.LOG2_WIDTH(2)) bus ();

  shift_subtractor #(.LOG2_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor gives all ones and the dividend.
  function automatic res_t ref_div(input logic [3:0] a, input logic [3:0] b);
    res_t res;
    if (b == 4'd0) begin
      res.q = 4'hF;
      res.r = a;
    end else begin
      res.q = a / b;
      res.r = a % b;
    end
    return res;
  endfunction

  function automatic int lat_of(input logic [3:0] b);
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
    if (b == 4'd0) return 0;
`endif
    return W;
  endfunction

  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edz);
    int k;
    bit seen;
    @(negedge clk);
    check("ready_before_accept", 32'(bus.din_ready), 32'd1);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.dividend  = 4'($urandom);
    bus.divisor   = 4'($urandom);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (bus.dout_valid) seen = 1'b1;
      else k++;
    end
    check("dout_valid_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("quotient", 32'(bus.quotient), 32'(eq));
      check("remainder", 32'(bus.remainder), 32'(er));
      check("latency", 32'(k), 32'(lat_of(b)));
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
      check("div_zero", 32'(bus.div_zero), 32'(edz));
`else
      if (edz !== 1'b0 && edz !== 1'b1) check("dz_arg", 32'(edz), 32'd0);
`endif
      check("ready_during_done", 32'(bus.din_ready), 32'd0);
      @(negedge clk);
      check("dout_valid_one_cycle", 32'(bus.dout_valid), 32'd0);
      check("ready_after_done", 32'(bus.din_ready), 32'd1);
      check("quotient_hold", 32'(bus.quotient), 32'(eq));
    end
  endtask

  vec_t tbl[6];
  res_t exp_q[$];
  res_t got;
  logic [3:0] a_s, b_s;
  int last_acc;

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, dz: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0};
    tbl[2] = '{a: 4'd5,  b: 4'd7, q: 4'd0,  r: 4'd5, dz: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd9, q: 4'd0,  r: 4'd0, dz: 1'b0};
    tbl[4] = '{a: 4'd9,  b: 4'd0, q: 4'd15, r: 4'd9, dz: 1'b1};
    tbl[5] = '{a: 4'd8,  b: 4'd2, q: 4'd4,  r: 4'd0, dz: 1'b0};

    rst_n         = 1'b0;
    bus.din_valid = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.din_ready), 32'd1);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
`ifdef SHIFT_SUBTRACTOR_DIV0_EN
    check("rst_div_zero", 32'(bus.div_zero), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        got = ref_div(4'(a), 4'(b));
        do_div(4'(a), 4'(b), got.q, got.r, 1'b0);
      end
    end

    for (int i = 0; i < 40; i++) begin
      a_s = 4'($urandom);
      b_s = 4'($urandom_range(0, 15));
      got = ref_div(a_s, b_s);
      do_div(a_s, b_s, got.q, got.r, (b_s == 4'd0));
    end

    // din_valid held high with operands changing every cycle.
    last_acc = -1;
    @(negedge clk);
    bus.din_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (bus.dout_valid) begin
        check("stream_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("stream_quotient", 32'(bus.quotient), 32'(got.q));
          check("stream_remainder", 32'(bus.remainder), 32'(got.r));
        end
      end
      bus.dividend = 4'($urandom);
      bus.divisor  = 4'($urandom_range(1, 15));
      if (bus.din_ready) begin
        exp_q.push_back(ref_div(bus.dividend, bus.divisor));
        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
      end
    end
    bus.din_valid = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.dout_valid && exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check("drain_quotient", 32'(bus.quotient), 32'(got.q));
        check("drain_remainder", 32'(bus.remainder), 32'(got.r));
      end
    end
    check("stream_all_results", 32'(exp_q.size()), 32'd0);

    // Reset pulse during the second CALC step of 14 / 3.
    @(negedge clk);
    bus.dividend  = 4'd14;
    bus.divisor   = 4'd3;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_v;
      seen_v = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        @(negedge clk);
        if (bus.dout_valid) seen_v++;
      end
      check("abort_no_dout_valid", 32'(seen_v), 32'd0);
    end
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_ready", 32'(bus.din_ready), 32'd1);
    do_div(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/shift_subtractor.md
# shift_subtractor

Iterative restoring (shift-subtract) unsigned divider: the inverse of the team's parallel shift-add multiplier. It accepts a dividend/divisor pair under a valid/ready handshake and produces quotient and remainder after one subtract step per bit. It sits beside the multiplier in the basic-compute library, for datapaths that need division without a combinational array.

## Interface
- `LOG2_WIDTH`, default 2: log2 of the operand width.
- `WIDTH`, derived as 2**LOG2_WIDTH (localparam, not overridable): operand width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `dividend` in WIDTH: numerator, unsigned.
- `divisor` in WIDTH: denominator, unsigned.
- `din_valid` in 1: operands valid.
- `din_ready` out 1: block idle, can accept operands.
- `quotient` out WIDTH: registered result.
- `remainder` out WIDTH: registered result.
- `dout_valid` out 1: single-cycle result strobe.
- `div_zero` out 1: divide-by-zero flag. Exists only with `SHIFT_SUBTRACTOR_DIV0_EN`.

One clock; reset is asynchronous and active-low, on ports `clk` and `rst_n`.

## Operation
- States:
  - IDLE, reset state.
  - CALC.
  - DONE.
- `din_ready` = (state == IDLE). Operands are accepted on a rising edge where `din_valid && din_ready`.
- On accept:
  - Latch the dividend into the quotient/shift register.
  - Latch the divisor.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set step counter = 0 (LOG2_WIDTH bits).
  - Go to CALC.
- CALC step, one per clock:
  - Shift the partial remainder left and bring in the dividend MSB. Shift the dividend left.
  - If remainder ≥ divisor: subtract it and shift in quotient bit 1; else shift in 0.
  - counter += 1.
- At the step where counter == WIDTH-1:
  - Register `quotient` and `remainder` from the final step.
  - Go to DONE.
- DONE: `dout_valid`=1 for exactly that one cycle, then IDLE.
- `quotient`/`remainder` hold their value until the next result is written.
- `din_valid` while not ready is ignored. Nothing is queued; the source must hold or retry.
- Divisor 0, default build: the algorithm runs unchanged and yields `quotient` = all ones, `remainder` = `dividend`.
- Reset values: state IDLE, `din_ready`=1, `dout_valid`=0, `quotient`=0, `remainder`=0, `div_zero`=0, counter 0.
- Reset asserted mid-CALC: the operation is aborted and no `dout_valid` is produced. The block is idle after release.

## Timing
- Accept edge = E.
- CALC steps occur at edges E+1 … E+WIDTH. Results and the DONE state are registered at edge E+WIDTH.
- `dout_valid` is high for the cycle between E+WIDTH and E+WIDTH+1.
- `din_ready` rises after edge E+WIDTH+1.
- Earliest next accept is at edge E+WIDTH+2, giving throughput of one division per WIDTH+2 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `SHIFT_SUBTRACTOR_DIV0_EN` defined:
  - Adds the `div_zero` port.
  - An accept with divisor==0 bypasses CALC: at edge E it goes directly to DONE with `quotient` = all ones, `remainder` = `dividend`, `div_zero`=1.
  - `dout_valid` is high in the cycle after E.
  - `div_zero` is cleared on every other result and holds with the results.
- `SHIFT_SUBTRACTOR_DIV0_EN` undefined:
  - No `div_zero` port.
  - Zero divisor takes the full WIDTH-step path with the result defined above.

## Structure
- `shift_subtractor_pkg`:
  - State encoding localparams IDLE/CALC/DONE.
  - Helper constant for remainder width (WIDTH+1).
- Sub-module `div_step`: a combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - The FSM and registers stay in `shift_subtractor`.

## Test plan
All scenarios use LOG2_WIDTH=2 (WIDTH=4).
- 13 ÷ 3 → `quotient`=4, `remainder`=1; `dout_valid` in the cycle after the 4th edge following accept, for one cycle only.
- 15 ÷ 1 → 15 r 0; 5 ÷ 7 → 0 r 5; 0 ÷ 9 → 0 r 0. Then an exhaustive 16×15 nonzero-divisor sweep against a reference model.
- 9 ÷ 0 → 15 r 9. Without the macro: latency 4. With the macro: `div_zero`=1, `dout_valid` the cycle after accept; a following 8 ÷ 2 → 4 r 0 with `div_zero`=0.
- `din_valid` held high continuously with changing operands → only operands present on ready edges are divided; back-to-back spacing is WIDTH+2 cycles.
- `rst_n` pulsed low during the 2nd CALC step of 14 ÷ 3 → no `dout_valid`; outputs 0; `din_ready`=1. A subsequent 14 ÷ 3 → 4 r 2.
